fft_bin_serializer: RTL and testbench

//  Sits on the output side of the combinational top_fft core.
//  - Captures one full parallel frame of POINT_FFT complex bins (data_o of top_fft) in a single cycle.
//  - Streams the bins out one per cycle, in natural index order k = 0..POINT_FFT-1, over a valid/ready interface.
//  - Ping-pong double buffer: the next frame is captured while the current one drains, so one frame per POINT_FFT cycles is sustained.

---
 rtl/fft_pkg.sv | 30 +++
 rtl/fft_frame_bank.sv | 34 +++
 rtl/fft_bin_serializer.sv | 109 ++++++++++
 tb/tb_fft_bin_serializer.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fft_pkg
// Brief   : Shared types and constants for top_fft and its output serializer.
// Revision: 1.0 - initial release
// ============================================================================
package fft_pkg;

    localparam int FRAC_BITS      = 15;
    localparam int POINT_FFT_POW2 = 4;

    localparam int RE = 0;
    localparam int IM = 1;

    function automatic int point_fft(input int pow2);
        return 1 << pow2;
    endfunction

    localparam int POINT_FFT = point_fft(POINT_FFT_POW2);

    // Index 0 = real part, index 1 = imaginary part, each Q1.FRAC_BITS.
    typedef logic signed [1:0][FRAC_BITS:0] cplx_t;

    typedef enum logic [0:0] {
        RD_IDLE   = 1'b0,
        RD_STREAM = 1'b1
    } rd_state_t;

endpackage
`default_nettype wire

// File: rtl/fft_frame_bank.sv
`default_nettype none
// ============================================================================
// Module  : fft_frame_bank
// Brief   : One frame of complex bins; whole-frame write, indexed read.
// Revision: 1.0 - initial release
// ============================================================================
module fft_frame_bank
    import fft_pkg::*;
#(
    parameter int POINT_FFT_POW2 = 4
) (
    input  logic                      clk,
    input  logic                      i_we,
    input  cplx_t                     i_frame [0:(1<<POINT_FFT_POW2)-1],
    input  logic [POINT_FFT_POW2-1:0] i_rd_idx,
    output cplx_t                     o_rd_data
);

    localparam int N_BINS = point_fft(POINT_FFT_POW2);

    cplx_t r_mem [0:N_BINS-1];

    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int k = 0; k < N_BINS; k++) begin
                r_mem[k] <= i_frame[k];
            end
        end
    end

    assign o_rd_data = r_mem[i_rd_idx];

endmodule
`default_nettype wire

// File: rtl/fft_bin_serializer.sv
`default_nettype none
// ============================================================================
// Module  : fft_bin_serializer
// Brief   : Ping-pong buffers parallel FFT frames and streams bins k=0..N-1.
// Revision: 1.0 - initial release
// ============================================================================
module fft_bin_serializer
    import fft_pkg::*;
#(
    parameter int POINT_FFT_POW2 = 4,
    parameter int FRAC_BITS      = fft_pkg::FRAC_BITS,
    parameter int NORM_SHIFT     = 0
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        frame_valid_i,
    output logic                        frame_ready_o,
    input  cplx_t                       frame_i [0:(1<<POINT_FFT_POW2)-1],
    output logic                        bin_valid_o,
    input  logic                        bin_ready_i,
    output logic signed [FRAC_BITS:0]   bin_re_o,
    output logic signed [FRAC_BITS:0]   bin_im_o,
    output logic [POINT_FFT_POW2-1:0]   bin_idx_o,
    output logic                        bin_last_o
);

    logic [1:0]                r_bank_full;
    logic                      r_wr_bank;
    logic                      r_rd_bank;
    logic [POINT_FFT_POW2-1:0] r_rd_idx;

    rd_state_t                 w_rd_state;
    logic                      w_capture;
    logic                      w_bin_hs;
    logic                      w_last;
    cplx_t                     w_bank_data [0:1];
    cplx_t                     w_rd_data;
    logic signed [FRAC_BITS:0] w_re_shift;
    logic signed [FRAC_BITS:0] w_im_shift;

    // Reader state is a pure decode of the bank flags, so it needs no register.
    always_comb begin
        w_rd_state = RD_IDLE;
        if (!rst_i && r_bank_full[r_rd_bank]) begin
            w_rd_state = RD_STREAM;
        end
    end

    assign frame_ready_o = !rst_i && !r_bank_full[r_wr_bank];
    assign w_capture     = frame_valid_i && frame_ready_o;
    assign bin_valid_o   = (w_rd_state == RD_STREAM);
    assign w_bin_hs      = bin_valid_o && bin_ready_i;
    assign w_last        = &r_rd_idx;
    assign bin_last_o    = bin_valid_o && w_last;

    // A capturing bank is empty and a draining bank is full, so the two
    // bank_full updates below never target the same bit.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_bank_full <= '0;
            r_wr_bank   <= 1'b0;
            r_rd_bank   <= 1'b0;
            r_rd_idx    <= '0;
        end else begin
            if (w_capture) begin
                r_bank_full[r_wr_bank] <= 1'b1;
                r_wr_bank              <= ~r_wr_bank;
            end
            if (w_bin_hs) begin
                r_rd_idx <= r_rd_idx + 1'b1;
                if (w_last) begin
                    r_bank_full[r_rd_bank] <= 1'b0;
                    r_rd_bank              <= ~r_rd_bank;
                end
            end
        end
    end

    generate
        for (genvar b = 0; b < 2; b++) begin : g_bank
            fft_frame_bank #(
                .POINT_FFT_POW2 (POINT_FFT_POW2)
            ) u_bank (
                .clk       (clk_i),
                .i_we      (w_capture && (r_wr_bank == 1'(b))),
                .i_frame   (frame_i),
                .i_rd_idx  (r_rd_idx),
                .o_rd_data (w_bank_data[b])
            );
        end
    endgenerate

    assign w_rd_data  = w_bank_data[r_rd_bank];
    assign w_re_shift = $signed(w_rd_data[RE]) >>> NORM_SHIFT;
    assign w_im_shift = $signed(w_rd_data[IM]) >>> NORM_SHIFT;

    always_comb begin
        bin_re_o  = '0;
        bin_im_o  = '0;
        bin_idx_o = '0;
        if (bin_valid_o) begin
            bin_re_o  = w_re_shift;
            bin_im_o  = w_im_shift;
            bin_idx_o = r_rd_idx;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fft_bin_serializer.sv
`default_nettype none
// ============================================================================
// Module  : tb_fft_bin_serializer
// Brief   : Scoreboard bench for fft_bin_serializer (shift 0 and shift 4).
// Revision: 1.0 - initial release
// ============================================================================
module tb_fft_bin_serializer;
    import fft_pkg::*;

    typedef struct {
        logic signed [15:0] re;
        logic signed [15:0] im;
        logic [3:0]         idx;
        logic               last;
    } beat_t;

    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic               rst_i         = 1'b1;
    logic               frame_valid_i = 1'b0;
    logic               bin_ready_i   = 1'b0;
    cplx_t              frame_i [0:15];
    logic               frame_ready_o;
    logic               bin_valid_o;
    logic signed [15:0] bin_re_o;
    logic signed [15:0] bin_im_o;
    logic [3:0]         bin_idx_o;
    logic               bin_last_o;

    logic               frame_valid2 = 1'b0;
    logic               bin_ready2   = 1'b1;
    cplx_t              frame2 [0:15];
    logic               frame_ready2;
    logic               bin_valid2;
    logic signed [15:0] bin_re2;
    logic signed [15:0] bin_im2;
    logic [3:0]         bin_idx2;
    logic               bin_last2;

    int    n_tests = 0;
    int    n_fail  = 0;
    int    n_last  = 0;
    beat_t q[$];
    beat_t q2[$];

    fft_bin_serializer #(.POINT_FFT_POW2(4), .FRAC_BITS(15), .NORM_SHIFT(0)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .frame_valid_i(frame_valid_i),
        .frame_ready_o(frame_ready_o), .frame_i(frame_i), .bin_valid_o(bin_valid_o),
        .bin_ready_i(bin_ready_i), .bin_re_o(bin_re_o), .bin_im_o(bin_im_o),
        .bin_idx_o(bin_idx_o), .bin_last_o(bin_last_o)
    );

    fft_bin_serializer #(.POINT_FFT_POW2(4), .FRAC_BITS(15), .NORM_SHIFT(4)) dut_ns (
        .clk_i(clk_i), .rst_i(rst_i), .frame_valid_i(frame_valid2),
        .frame_ready_o(frame_ready2), .frame_i(frame2), .bin_valid_o(bin_valid2),
        .bin_ready_i(bin_ready2), .bin_re_o(bin_re2), .bin_im_o(bin_im2),
        .bin_idx_o(bin_idx2), .bin_last_o(bin_last2)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Frame 0 is the k*256 / -k ramp; other frames add a per-frame offset.
    function automatic logic signed [15:0] re_of(input int f, input int k);
        return 16'(k * 256 + f * 7);
    endfunction

    function automatic logic signed [15:0] im_of(input int f, input int k);
        return 16'(-k - f * 100);
    endfunction

    task automatic load_frame(input int f);
        for (int k = 0; k < 16; k++) begin
            frame_i[k][RE] = re_of(f, k);
            frame_i[k][IM] = im_of(f, k);
        end
    endtask

    task automatic push_frame(input int f);
        beat_t b;
        for (int k = 0; k < 16; k++) begin
            b.re   = re_of(f, k);
            b.im   = im_of(f, k);
            b.idx  = 4'(k);
            b.last = (k == 15);
            q.push_back(b);
        end
    endtask

    // Called just after a rising edge; returns just after the capturing edge.
    task automatic send_frame(input int f);
        bit rdy;
        int t;
        rdy = 1'b0;
        t   = 0;
        load_frame(f);
        frame_valid_i = 1'b1;
        while (!rdy && t < 400) begin
            @(negedge clk_i);
            rdy = frame_ready_o;
            @(posedge clk_i);
            t++;
        end
        if (rdy) push_frame(f);
        else chk("capture_timeout", 0, 1);
        #1;
        frame_valid_i = 1'b0;
        for (int k = 0; k < 16; k++) frame_i[k] = '1;
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while ((q.size() != 0 || q2.size() != 0) && t < 2000) begin
            @(posedge clk_i);
            t++;
        end
        chk("drain_q", q.size(), 0);
        chk("drain_q2", q2.size(), 0);
    endtask

    always @(negedge clk_i) begin : mon_main
        beat_t e;
        if (bin_valid_o && bin_ready_i) begin
            if (q.size() == 0) begin
                chk("unexpected_beat_idx", bin_idx_o, -1);
            end else begin
                e = q.pop_front();
                chk("bin_re", bin_re_o, e.re);
                chk("bin_im", bin_im_o, e.im);
                chk("bin_idx", bin_idx_o, e.idx);
                chk("bin_last", bin_last_o, e.last);
            end
            if (bin_last_o) n_last++;
        end
    end

    always @(negedge clk_i) begin : mon_shift
        beat_t e;
        if (bin_valid2 && bin_ready2) begin
            if (q2.size() == 0) begin
                chk("ns_unexpected_beat_idx", bin_idx2, -1);
            end else begin
                e = q2.pop_front();
                chk("ns_re", bin_re2, e.re);
                chk("ns_im", bin_im2, e.im);
                chk("ns_idx", bin_idx2, e.idx);
                chk("ns_last", bin_last2, e.last);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got %0d failures so far", n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        int    re_in  [4];
        int    re_out [4];
        int    bubbles;
        int    beats;
        int    lbase;
        int    lat;
        int    t;
        bit    rdy;
        beat_t b;
        logic signed [15:0] s_re, s_im;
        logic [3:0]         s_idx;
        int    pat [4];

        re_in  = '{-32768, 15, -1, 32767};
        re_out = '{-2048, 0, -1, 2047};
        pat    = '{1, 0, 1, 0};

        // Reset with a frame offered: nothing may be captured.
        rst_i         = 1'b1;
        frame_valid_i = 1'b1;
        bin_ready_i   = 1'b1;
        load_frame(55);
        for (int k = 0; k < 16; k++) frame2[k] = '0;
        repeat (3) begin
            @(negedge clk_i);
            chk("rst_frame_ready", frame_ready_o, 0);
            chk("rst_bin_valid", bin_valid_o, 0);
        end
        @(posedge clk_i);
        #1;
        rst_i         = 1'b0;
        frame_valid_i = 1'b0;
        @(negedge clk_i);
        chk("post_rst_ready", frame_ready_o, 1);
        chk("post_rst_valid", bin_valid_o, 0);

        // NORM_SHIFT=4 instance: floor shift on Re, Im = -16k-8 -> -k-1.
        @(posedge clk_i);
        #1;
        for (int k = 0; k < 16; k++) begin
            frame2[k][RE] = (k < 4) ? 16'(re_in[k]) : 16'(0);
            frame2[k][IM] = 16'(-16 * k - 8);
        end
        frame_valid2 = 1'b1;
        @(negedge clk_i);
        chk("ns_frame_ready", frame_ready2, 1);
        @(posedge clk_i);
        for (int k = 0; k < 16; k++) begin
            b.re   = (k < 4) ? 16'(re_out[k]) : 16'(0);
            b.im   = 16'(-k - 1);
            b.idx  = 4'(k);
            b.last = (k == 15);
            q2.push_back(b);
        end
        #1;
        frame_valid2 = 1'b0;
        for (int k = 0; k < 16; k++) frame2[k] = '1;

        // Single frame: bin 0 the cycle after capture, 16 contiguous beats.
        lbase = n_last;
        send_frame(0);
        @(negedge clk_i);
        chk("latency_valid", bin_valid_o, 1);
        chk("latency_idx", bin_idx_o, 0);
        bubbles = 0;
        for (int i = 1; i < 16; i++) begin
            @(negedge clk_i);
            if (!bin_valid_o) bubbles++;
        end
        chk("single_bubbles", bubbles, 0);
        @(negedge clk_i);
        chk("single_idle_after", bin_valid_o, 0);
        wait_drain();
        chk("single_last_count", n_last - lbase, 1);

        // Back-to-back: three frames, 48 contiguous beats.
        @(posedge clk_i);
        #1;
        lbase = n_last;
        fork
            begin
                send_frame(1);
                send_frame(2);
                send_frame(3);
            end
            begin
                t = 0;
                @(negedge clk_i);
                while (!bin_valid_o && t < 100) begin
                    @(negedge clk_i);
                    t++;
                end
                beats = bin_valid_o ? 1 : 0;
                for (int i = 1; i < 48; i++) begin
                    @(negedge clk_i);
                    if (bin_valid_o) beats++;
                end
                chk("b2b_contiguous_beats", beats, 48);
            end
        join
        wait_drain();
        chk("b2b_last_count", n_last - lbase, 3);

        // Backpressure at k=7 with a third frame waiting on a free bank.
        #1;
        lbase = n_last;
        send_frame(4);
        send_frame(5);
        t = 0;
        while (!(bin_valid_o && bin_idx_o == 4'd7) && t < 100) begin
            @(posedge clk_i);
            #1;
            t++;
        end
        chk("bp_reached_k7", bin_idx_o, 7);
        bin_ready_i = 1'b0;
        s_re  = bin_re_o;
        s_im  = bin_im_o;
        s_idx = bin_idx_o;
        repeat (5) begin
            @(negedge clk_i);
            chk("stall_valid", bin_valid_o, 1);
            chk("stall_idx", bin_idx_o, s_idx);
            chk("stall_re", bin_re_o, s_re);
            chk("stall_im", bin_im_o, s_im);
        end
        fork
            begin
                for (int i = 0; i < 4; i++) begin
                    @(posedge clk_i);
                    #1;
                    bin_ready_i = pat[i][0];
                end
                @(posedge clk_i);
                #1;
                bin_ready_i = 1'b1;
            end
            begin
                load_frame(6);
                frame_valid_i = 1'b1;
                rdy = 1'b0;
                t   = 0;
                while (t < 200) begin
                    @(posedge clk_i);
                    if (rdy) break;
                    lat = n_last;
                    @(negedge clk_i);
                    rdy = frame_ready_o;
                    chk("bp_third_frame_ready", rdy, (lat > lbase) ? 1 : 0);
                    t++;
                end
                if (rdy) push_frame(6);
                else chk("bp_capture_timeout", 0, 1);
                #1;
                frame_valid_i = 1'b0;
                for (int k = 0; k < 16; k++) frame_i[k] = '1;
            end
        join
        wait_drain();
        chk("bp_last_count", n_last - lbase, 3);

        // Mid-stream reset at k=5 with a second frame buffered.
        #1;
        send_frame(7);
        send_frame(8);
        t = 0;
        while (!(bin_valid_o && bin_idx_o == 4'd5) && t < 100) begin
            @(posedge clk_i);
            #1;
            t++;
        end
        chk("mr_reached_k5", bin_idx_o, 5);
        rst_i = 1'b1;
        q.delete();
        lbase = n_last;
        @(negedge clk_i);
        chk("mr_valid_in_rst", bin_valid_o, 0);
        chk("mr_last_in_rst", bin_last_o, 0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        @(negedge clk_i);
        chk("mr_valid_after", bin_valid_o, 0);
        chk("mr_ready_after", frame_ready_o, 1);
        @(posedge clk_i);
        #1;
        send_frame(9);
        @(negedge clk_i);
        chk("mr_new_valid", bin_valid_o, 1);
        chk("mr_new_idx", bin_idx_o, 0);
        wait_drain();
        chk("mr_last_count", n_last - lbase, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
